// File: rtl/xm23_pkg.sv
// Shared types for the XM23 fetch stage: state encoding, FIFO entry layout, PC stepping.
package xm23_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD,
        HALT
    } fetch_state_e;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

    localparam word_t PC_STEP = 16'd2;

    // 16-bit add wraps 16'hFFFE -> 16'h0000 by itself.
    function automatic word_t next_pc(input word_t pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction FIFO of {pc, instr} entries; synchronous flush wins over a same-cycle push.
module fetch_fifo
    import xm23_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry_t                 push_data,
    output fetch_entry_t                 head,
    output logic [$clog2(BUF_DEPTH):0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    fetch_entry_t  mem_q [BUF_DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == (AW + 1)'(BUF_DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/instruction_fetch_stage.sv
// XM23 fetch stage: PC, req/ack instruction memory FSM, FIFO and stall-aware output register.
// Define FETCH_PERF_CNT_EN to add the saturating fetch/stall performance counters.
module instruction_fetch_stage
    import xm23_pkg::*;
#(
    parameter word_t       RESET_PC  = 16'h0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  stall_in,
    input  logic        redirect_i,
    input  logic [15:0] redirect_pc_i,
    input  logic        sleep_i,
    input  logic        wake_i,
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [15:0] imem_rdata_i,
    output logic [15:0] fetch_o,
    output logic [15:0] fetch_pc_o,
    output logic        fetch_valid_o,
    output logic        halted_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt_o,
    output logic [31:0] perf_stall_cnt_o
`endif
);

    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_e state_q, state_d;
    word_t        pc_q, pc_d, addr_q, addr_d;
    logic         sleep_pend_q, sleep_pend_d;
    word_t        fetch_q, fetch_pc_q;
    logic         fetch_valid_q;

    fetch_entry_t fifo_head, out_entry;
    logic [CW-1:0] fifo_count, cnt_next;
    logic         fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic         stall, busy, accept, take, space, sleep_now;

    assign stall     = |stall_in;
    assign busy      = (state_q == REQ) || (state_q == DISCARD);
    assign accept    = (state_q == REQ) && imem_ack_i && !redirect_i;
    assign take      = !redirect_i && !stall && (!fifo_empty || accept);
    // An empty FIFO is bypassed so a returning word reaches fetch_o one cycle after its ack.
    assign fifo_pop  = take && !fifo_empty;
    assign fifo_push = accept && !(take && fifo_empty);
    assign out_entry = fifo_empty ? '{pc: pc_q, instr: imem_rdata_i} : fifo_head;
    assign cnt_next  = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    assign space     = cnt_next < CW'(BUF_DEPTH);
    assign sleep_now = sleep_i || sleep_pend_q;

    fetch_fifo #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .flush     (redirect_i),
        .push_data ('{pc: pc_q, instr: imem_rdata_i}),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        sleep_pend_d = sleep_pend_q | sleep_i;
        if (redirect_i) begin
            pc_d = redirect_pc_i & 16'hFFFE;
            if (busy && !imem_ack_i) state_d = DISCARD;
            else if (sleep_now)      state_d = HALT;
            else                     state_d = REQ;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sleep_now)       state_d = HALT;
                    else if (!fifo_full) state_d = REQ;
                end
                REQ: begin
                    if (imem_ack_i) begin
                        pc_d    = next_pc(pc_q);
                        state_d = sleep_now ? HALT : (space ? REQ : IDLE);
                    end
                end
                DISCARD: if (imem_ack_i) state_d = sleep_now ? HALT : REQ;
                HALT:    if (wake_i) state_d = space ? REQ : IDLE;
                default: state_d = IDLE;
            endcase
        end
        if (state_d == HALT) sleep_pend_d = 1'b0;
        // The address of an abandoned request stays on the bus until its ack arrives.
        if (state_d == REQ)          addr_d = pc_d;
        else if (state_d == DISCARD) addr_d = addr_q;
        else                         addr_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC & 16'hFFFE;
            addr_q        <= '0;
            sleep_pend_q  <= 1'b0;
            fetch_q       <= '0;
            fetch_pc_q    <= '0;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            sleep_pend_q <= sleep_pend_d;
            if (redirect_i) begin
                fetch_q       <= '0;
                fetch_valid_q <= 1'b0;
            end else if (!stall) begin
                if (take) begin
                    fetch_q       <= out_entry.instr;
                    fetch_pc_q    <= out_entry.pc;
                    fetch_valid_q <= 1'b1;
                end else begin
                    fetch_q       <= '0;
                    fetch_valid_q <= 1'b0;
                end
            end
        end
    end

    assign imem_req_o    = busy;
    assign imem_addr_o   = addr_q;
    assign fetch_o       = fetch_q;
    assign fetch_pc_o    = fetch_pc_q;
    assign fetch_valid_o = fetch_valid_q;
    assign halted_o      = (state_q == HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (take && perf_fetch_q != 32'hFFFF_FFFF) perf_fetch_q <= perf_fetch_q + 32'd1;
            if (stall && fetch_valid_q && perf_stall_q != 32'hFFFF_FFFF) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt_o = perf_fetch_q;
    assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: sequential fetch, stall, redirect, PC wrap,
// sleep/wake and mid-request reset against a latency-programmable memory model.
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  stall_in;
    logic        redirect_i;
    logic [15:0] redirect_pc_i;
    logic        sleep_i;
    logic        wake_i;
    logic        imem_req_o, imem_ack_i;
    logic [15:0] imem_addr_o, imem_rdata_i;
    logic [15:0] fetch_o, fetch_pc_o;
    logic        fetch_valid_o, halted_o;

    logic        req2, ack2, valid2, halted2;
    logic [15:0] addr2, rdata2, fetch2, fetch_pc2;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] pf1, ps1, pf2, ps2;
`endif

    int checks = 0;
    int failures = 0;
    int lat = 0;
    int wait_cnt = 0;
    int ack_cnt = 0;
    logic stale_ack = 1'b0;

    always #5 clk = ~clk;

    instruction_fetch_stage #(
        .RESET_PC  (16'h0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_in      (stall_in),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .sleep_i       (sleep_i),
        .wake_i        (wake_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .fetch_o       (fetch_o),
        .fetch_pc_o    (fetch_pc_o),
        .fetch_valid_o (fetch_valid_o),
        .halted_o      (halted_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt_o (pf1),
        .perf_stall_cnt_o (ps1)
`endif
    );

    instruction_fetch_stage #(
        .RESET_PC  (16'hFFFC),
        .BUF_DEPTH (2)
    ) dut_wrap (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_in      (8'h00),
        .redirect_i    (1'b0),
        .redirect_pc_i (16'h0000),
        .sleep_i       (1'b0),
        .wake_i        (1'b0),
        .imem_req_o    (req2),
        .imem_addr_o   (addr2),
        .imem_ack_i    (ack2),
        .imem_rdata_i  (rdata2),
        .fetch_o       (fetch2),
        .fetch_pc_o    (fetch_pc2),
        .fetch_valid_o (valid2),
        .halted_o      (halted2)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt_o (pf2),
        .perf_stall_cnt_o (ps2)
`endif
    );

    // Memory contents: word at byte address a is 16'h00A1 + a/2 (A1..A4 at 0..6).
    function automatic logic [15:0] word_at(input logic [15:0] a);
        return 16'h00A1 + (a >> 1);
    endfunction

    always_comb begin
        imem_ack_i   = (imem_req_o && wait_cnt >= lat) || stale_ack;
        imem_rdata_i = stale_ack ? 16'hDEAD : word_at(imem_addr_o);
        ack2         = req2;
        rdata2       = word_at(addr2);
    end

    always @(posedge clk) begin
        if (!imem_req_o || imem_ack_i) wait_cnt <= 0;
        else                           wait_cnt <= wait_cnt + 1;
        if (imem_req_o && imem_ack_i) ack_cnt <= ack_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int latency);
        rst_n = 1'b0;
        stall_in = 8'h00;
        redirect_i = 1'b0;
        redirect_pc_i = 16'h0000;
        sleep_i = 1'b0;
        wake_i = 1'b0;
        stale_ack = 1'b0;
        lat = latency;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall_in = 8'h00;
        redirect_i = 1'b0;
        redirect_pc_i = 16'h0000;
        sleep_i = 1'b0;
        wake_i = 1'b0;
        lat = 0;
        step();
        step();
        checks++;
        if (imem_req_o !== 1'b0 || imem_addr_o !== 16'h0000) begin
            failures++;
            $display("FAIL reset_imem req=%b addr=%h expected req=0 addr=0000", imem_req_o,
                     imem_addr_o);
        end
        checks++;
        if (fetch_o !== 16'h0000 || fetch_pc_o !== 16'h0000 || fetch_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_fetch fetch=%h pc=%h valid=%b expected 0000 0000 0", fetch_o,
                     fetch_pc_o, fetch_valid_o);
        end
        checks++;
        if (halted_o !== 1'b0 || req2 !== 1'b0 || valid2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_misc halted=%b req2=%b valid2=%b expected 0 0 0", halted_o, req2,
                     valid2);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        logic [15:0] exp_w, exp_pc;
        do_reset(0);
        step();
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 16'h0000) begin
            failures++;
            $display("FAIL seq_first_req req=%b addr=%h expected 1 0000", imem_req_o, imem_addr_o);
        end
        for (int i = 0; i < 4; i++) begin
            exp_w  = 16'h00A1 + 16'(i);
            exp_pc = 16'(2 * i);
            step();
            checks++;
            if (fetch_valid_o !== 1'b1 || fetch_o !== exp_w || fetch_pc_o !== exp_pc) begin
                failures++;
                $display("FAIL seq_word%0d got v=%b %h@%h expected 1 %h@%h", i, fetch_valid_o,
                         fetch_o, fetch_pc_o, exp_w, exp_pc);
            end
        end
    endtask

    task automatic test_stall();
        int a0;
        logic [15:0] exp_w;
        do_reset(0);
        step();
        step();
        step();
        checks++;
        if (fetch_o !== 16'h00A2 || fetch_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL stall_pre got %h v=%b expected 00a2 1", fetch_o, fetch_valid_o);
        end
        a0 = ack_cnt;
        stall_in = 8'h01;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (fetch_o !== 16'h00A2 || fetch_pc_o !== 16'h0002 || fetch_valid_o !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold%0d got %h@%h v=%b expected 00a2@0002 1", i, fetch_o,
                         fetch_pc_o, fetch_valid_o);
            end
        end
        stall_in = 8'h00;
        checks++;
        if (ack_cnt - a0 != 2) begin
            failures++;
            $display("FAIL stall_prefetch got %0d words expected 2", ack_cnt - a0);
        end
        for (int i = 0; i < 3; i++) begin
            exp_w = 16'h00A3 + 16'(i);
            step();
            checks++;
            if (fetch_o !== exp_w || fetch_pc_o !== 16'(4 + 2 * i) || fetch_valid_o !== 1'b1) begin
                failures++;
                $display("FAIL stall_resume%0d got %h@%h v=%b expected %h@%h 1", i, fetch_o,
                         fetch_pc_o, fetch_valid_o, exp_w, 16'(4 + 2 * i));
            end
        end
    endtask

    task automatic test_redirect();
        int n;
        logic early;
        do_reset(3);
        step();
        redirect_i = 1'b1;
        redirect_pc_i = 16'h0041;
        step();
        redirect_i = 1'b0;
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 16'h0000 || fetch_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL redir_hold req=%b addr=%h v=%b expected 1 0000 0", imem_req_o,
                     imem_addr_o, fetch_valid_o);
        end
        n = 0;
        early = 1'b0;
        while (!(imem_req_o && imem_addr_o == 16'h0040) && n < 20) begin
            if (fetch_valid_o) early = 1'b1;
            step();
            n++;
        end
        checks++;
        if (n != 3 || early || fetch_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL redir_new_addr got cycles=%0d early=%b v=%b expected 3 0 0", n, early,
                     fetch_valid_o);
        end
        n = 0;
        while (!fetch_valid_o && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n != 4 || fetch_o !== 16'h00C1 || fetch_pc_o !== 16'h0040) begin
            failures++;
            $display("FAIL redir_target got cycles=%0d %h@%h expected 4 00c1@0040", n, fetch_o,
                     fetch_pc_o);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_pc [3];
        logic [15:0] exp_w [3];
        exp_pc = '{16'hFFFC, 16'hFFFE, 16'h0000};
        exp_w  = '{16'h809F, 16'h80A0, 16'h00A1};
        do_reset(0);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (valid2 !== 1'b1 || fetch_pc2 !== exp_pc[i] || fetch2 !== exp_w[i]) begin
                failures++;
                $display("FAIL wrap%0d got v=%b %h@%h expected 1 %h@%h", i, valid2, fetch2,
                         fetch_pc2, exp_w[i], exp_pc[i]);
            end
        end
    endtask

    task automatic test_sleep();
        int n;
        logic idle_ok;
        do_reset(3);
        step();
        sleep_i = 1'b1;
        step();
        sleep_i = 1'b0;
        checks++;
        if (imem_req_o !== 1'b1 || halted_o !== 1'b0) begin
            failures++;
            $display("FAIL sleep_pending req=%b halted=%b expected 1 0", imem_req_o, halted_o);
        end
        n = 0;
        while (!halted_o && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n != 3 || fetch_valid_o !== 1'b1 || fetch_o !== 16'h00A1 || imem_req_o !== 1'b0) begin
            failures++;
            $display("FAIL sleep_enter got cycles=%0d v=%b %h req=%b expected 3 1 00a1 0", n,
                     fetch_valid_o, fetch_o, imem_req_o);
        end
        idle_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (imem_req_o !== 1'b0 || halted_o !== 1'b1) idle_ok = 1'b0;
        end
        checks++;
        if (!idle_ok) begin
            failures++;
            $display("FAIL sleep_quiet got req/halt activity while halted expected none");
        end
        wake_i = 1'b1;
        step();
        wake_i = 1'b0;
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 16'h0002 || halted_o !== 1'b0) begin
            failures++;
            $display("FAIL wake_req req=%b addr=%h halted=%b expected 1 0002 0", imem_req_o,
                     imem_addr_o, halted_o);
        end
        n = 0;
        while (!fetch_valid_o && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (fetch_valid_o !== 1'b1 || fetch_o !== 16'h00A2 || fetch_pc_o !== 16'h0002) begin
            failures++;
            $display("FAIL wake_word got v=%b %h@%h expected 1 00a2@0002", fetch_valid_o,
                     fetch_o, fetch_pc_o);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset(3);
        step();
        step();
        checks++;
        if (imem_req_o !== 1'b1) begin
            failures++;
            $display("FAIL rmid_pending req=%b expected 1", imem_req_o);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (imem_req_o !== 1'b0 || imem_addr_o !== 16'h0000 || fetch_o !== 16'h0000 ||
            fetch_pc_o !== 16'h0000 || fetch_valid_o !== 1'b0 || halted_o !== 1'b0) begin
            failures++;
            $display("FAIL rmid_outputs req=%b addr=%h f=%h pc=%h v=%b h=%b expected all zero",
                     imem_req_o, imem_addr_o, fetch_o, fetch_pc_o, fetch_valid_o, halted_o);
        end
        rst_n = 1'b1;
        stale_ack = 1'b1;
        step();
        stale_ack = 1'b0;
        checks++;
        if (fetch_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 16'h0000) begin
            failures++;
            $display("FAIL rmid_stale v=%b req=%b addr=%h expected 0 1 0000", fetch_valid_o,
                     imem_req_o, imem_addr_o);
        end
        n = 0;
        while (!fetch_valid_o && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (fetch_valid_o !== 1'b1 || fetch_o !== 16'h00A1 || fetch_pc_o !== 16'h0000) begin
            failures++;
            $display("FAIL rmid_first got v=%b %h@%h expected 1 00a1@0000", fetch_valid_o,
                     fetch_o, fetch_pc_o);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_wrap();
        test_sleep();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete expected finish before 100000");
        $fatal(1);
    end

endmodule
